// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch front end.
//
// Takes the committed fetch address and issues word reads to instruction
// memory over a req/ack handshake. Returned words are stored with their PCs
// in a 2**AW entry FIFO and presented to decode with a valid/ready handshake.
// A redirect flushes the FIFO, discards any read still in flight and restarts
// fetch at the (word-aligned) redirect address.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   redirect, redirect_pc flush and restart fetch at redirect_pc
//   imem_req, imem_addr   read request / word address (held until ack)
//   imem_ack, imem_rdata  read completion and returned instruction word
//   out_valid, out_ready  FIFO head handshake towards decode
//   out_instr, out_pc     FIFO head instruction and its PC
//   misalign              sticky misaligned-redirect flag
//
// Optional feature: define IFETCH_ALIGN_CHECK_EN to make misalign set on any
// redirect whose low two address bits are non-zero. When undefined, misalign
// is tied low and the low bits are masked silently.

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          AW       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE, // no request outstanding
        REQ,  // request outstanding, its data will be kept
        DROP  // request outstanding, its data will be discarded
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic          req_nxt;
    logic [31:0]   addr_nxt;
    logic [31:0]   aligned_pc;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_after;
    logic          push, pop;

    assign aligned_pc  = redirect_pc & 32'hFFFF_FFFC;
    assign push        = (state == REQ) && imem_ack && !redirect;
    assign pop         = out_valid && out_ready;
    assign count_after = count + (AW+1)'(push) - (AW+1)'(pop);

    assign out_valid = (count != '0);
    assign out_instr = instr_mem[rd_ptr];
    assign out_pc    = pc_mem[rd_ptr];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!redirect && count < DEPTH_C) state_nxt = REQ;
            REQ: begin
                if (imem_ack) begin
                    // Back-to-back only while the pushed word leaves a slot free.
                    if (redirect || count_after >= DEPTH_C) state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = DROP;
                end
            end
            DROP: if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered bus outputs and fetch PC.
    always_comb begin
        req_nxt      = imem_req;
        addr_nxt     = imem_addr;
        fetch_pc_nxt = fetch_pc;
        unique case (state)
            IDLE: begin
                if (!redirect && count < DEPTH_C) begin
                    req_nxt  = 1'b1;
                    addr_nxt = fetch_pc;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        req_nxt = 1'b0;
                    end else begin
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        if (count_after < DEPTH_C) addr_nxt = fetch_pc + 32'd4;
                        else                       req_nxt  = 1'b0;
                    end
                end
            end
            DROP: if (imem_ack) req_nxt = 1'b0;
            default: req_nxt = 1'b0;
        endcase
        // A redirect in any state retargets fetch; the in-flight request (if
        // any) keeps its address on the bus until it is acknowledged.
        if (redirect) fetch_pc_nxt = aligned_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
        end
    end

    // FIFO. A redirect wins over any push or pop in the same cycle.
    // NOTE: storage is reset so the head outputs read zero out of reset; this
    // is a tiny register-based FIFO, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                instr_mem[wr_ptr] <= imem_rdata;
                pc_mem[wr_ptr]    <= imem_addr;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_after;
        end
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 misalign <= 1'b0;
        else if (redirect && |redirect_pc[1:0]) misalign <= 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit -- directed, table-driven bench for ifetch_unit.
// Each table row gives the inputs for one clock cycle and the outputs expected
// during that cycle (before the edge that consumes the inputs). A hand-written
// sequence covers reset asserted in the middle of a transaction.

module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef IFETCH_ALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    localparam logic [31:0] I0 = 32'hA0A0_0001, I1 = 32'hA0A0_0002;
    localparam logic [31:0] I2 = 32'hA0A0_0003, I3 = 32'hA0A0_0004;
    localparam logic [31:0] I4 = 32'hA0A0_0005, I5 = 32'hA0A0_0006;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    ifetch_unit #(.RESET_PC(32'h0040_0000), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic rd, logic [31:0] rpc, logic ack,
                               logic [31:0] rdata, logic rdy, logic e_req,
                               logic [31:0] e_addr, logic e_valid,
                               logic [31:0] e_pc, logic [31:0] e_instr,
                               logic e_mis);
        vec_t x;
        x.rst = r; x.redir = rd; x.rpc = rpc; x.ack = ack; x.rdata = rdata;
        x.rdy = rdy; x.e_req = e_req; x.e_addr = e_addr; x.e_valid = e_valid;
        x.e_pc = e_pc; x.e_instr = e_instr; x.e_mis = e_mis;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reset row: reset asserted; all outputs must read zero.
    function automatic vec_t rrow();
        return v(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    endfunction

    initial begin
        // 1: streaming fetch, ack every cycle, decode always ready.
        tbl.push_back(rrow());
        tbl.push_back(v(0,0,0, 0,0,   1, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0, 1,I0,  1, 1,32'h0040_0000,0,0,0,           0));
        tbl.push_back(v(0,0,0, 1,I1,  1, 1,32'h0040_0004,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0, 1,I2,  1, 1,32'h0040_0008,1,32'h0040_0004,I1,0));
        tbl.push_back(v(0,0,0, 0,0,   1, 1,32'h0040_000C,1,32'h0040_0008,I2,0));
        tbl.push_back(v(0,0,0, 0,0,   1, 1,32'h0040_000C,0,0,0,           0));
        // 2: decode stalled, FIFO fills to 4, then one pop admits one request.
        tbl.push_back(rrow());
        tbl.push_back(v(0,0,0, 0,0,   0, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0, 1,I0,  0, 1,32'h0040_0000,0,0,0,           0));
        tbl.push_back(v(0,0,0, 1,I1,  0, 1,32'h0040_0004,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0, 1,I2,  0, 1,32'h0040_0008,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0, 1,I3,  0, 1,32'h0040_000C,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0, 0,0,   0, 0,0,           1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0, 0,0,   1, 0,0,           1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0, 0,0,   0, 0,0,           1,32'h0040_0004,I1,0));
        tbl.push_back(v(0,0,0, 0,0,   0, 1,32'h0040_0010,1,32'h0040_0004,I1,0));
        tbl.push_back(v(0,0,0, 1,I4,  0, 1,32'h0040_0010,1,32'h0040_0004,I1,0));
        tbl.push_back(v(0,0,0, 0,0,   0, 0,0,           1,32'h0040_0004,I1,0));
        // 3: redirect while the request to 0x00400008 waits for its ack.
        tbl.push_back(rrow());
        tbl.push_back(v(0,0,0,             0,0,   1, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I0,  1, 1,32'h0040_0000,0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I1,  1, 1,32'h0040_0004,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0040_0008,1,32'h0040_0004,I1,0));
        tbl.push_back(v(0,1,32'h0040_0100, 0,0,   1, 1,32'h0040_0008,0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0040_0008,0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,JUNK,1, 1,32'h0040_0008,0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   1, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0040_0100,0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I5,  1, 1,32'h0040_0100,0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0040_0104,1,32'h0040_0100,I5,0));
        // 4: redirect coincides with ack and pop while two entries are held.
        tbl.push_back(rrow());
        tbl.push_back(v(0,0,0,             0,0,   0, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I0,  0, 1,32'h0040_0000,0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I1,  0, 1,32'h0040_0004,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,1,32'h0040_0200, 1,I2,  1, 1,32'h0040_0008,1,32'h0040_0000,I0,0));
        tbl.push_back(v(0,0,0,             0,0,   1, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0040_0200,0,0,0,           0));
        // 5: fetch PC wraps from 0xFFFFFFFC to 0.
        tbl.push_back(rrow());
        tbl.push_back(v(0,1,32'hFFFF_FFFC, 0,0,   0, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   0, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I0,  0, 1,32'hFFFF_FFFC,0,0,0,           0));
        tbl.push_back(v(0,0,0,             1,I1,  0, 1,32'h0000_0000,1,32'hFFFF_FFFC,I0,0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0000_0004,1,32'hFFFF_FFFC,I0,0));
        tbl.push_back(v(0,0,0,             0,0,   1, 1,32'h0000_0004,1,32'h0000_0000,I1,0));
        // 6: misaligned redirect; low bits masked, flag sticky until reset.
        tbl.push_back(rrow());
        tbl.push_back(v(0,1,32'h0040_0102, 0,0,   0, 0,0,           0,0,0,           0));
        tbl.push_back(v(0,0,0,             0,0,   0, 0,0,           0,0,0,           EXP_MIS));
        tbl.push_back(v(0,0,0,             0,0,   0, 1,32'h0040_0100,0,0,0,           EXP_MIS));
        tbl.push_back(rrow());

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            rst         = tbl[i].rst;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            imem_ack    = tbl[i].ack;
            imem_rdata  = tbl[i].rdata;
            out_ready   = tbl[i].rdy;
            #1;
            check($sformatf("v%0d req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req || tbl[i].rst)
                check($sformatf("v%0d addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("v%0d valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid || tbl[i].rst) begin
                check($sformatf("v%0d pc", i), out_pc, tbl[i].e_pc);
                check($sformatf("v%0d instr", i), out_instr, tbl[i].e_instr);
            end
            check($sformatf("v%0d misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
            @(posedge clk); #1;
        end

        // Reset in the middle of a transaction, then a late ack in IDLE.
        rst = 1'b0; redirect = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
        begin
            int k = 0;
            while (!imem_req && k < 5) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("mid_rst wait req", 32'(imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst req", 32'(imem_req), 32'd0);
        check("mid_rst addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = JUNK;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        check("late_ack req", 32'(imem_req), 32'd1);
        check("late_ack addr", imem_addr, 32'h0040_0000);
        check("late_ack valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("late_ack valid2", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
